// File: rtl/fft_output_reorder.sv
// fft_output_reorder: streaming bit-reversal reorder buffer for the 16-point FFT.
// Samples arrive in bit-reversed order and are written into one bank of a
// ping-pong buffer. Each completed frame is replayed in natural frequency
// order from the other bank, one sample per clock.
// Optional feature: define FFT_OUT_SCALE_EN to divide every output word by N.
// The division is done by adjusting the IEEE-754 exponent field.
module fft_output_reorder #(
    parameter int DATA_W = 32,
    parameter int N      = 16,
    parameter int LOG2N  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              out_valid,
    output logic [LOG2N-1:0]  out_index,
    output logic              finish
);

    typedef enum logic {IDLE, READ} state_t;

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    state_t            state;
    state_t            next_state;
    logic [LOG2N-1:0]  wr_cnt;
    logic [LOG2N-1:0]  rd_cnt;
    logic              wr_bank;
    logic              rd_bank;
    logic              frame_done;
    logic              last_rd;
    logic [DATA_W-1:0] rd_real;
    logic [DATA_W-1:0] rd_imag;
    logic [DATA_W-1:0] nxt_real;
    logic [DATA_W-1:0] nxt_imag;

    logic [DATA_W-1:0] mem_real [0:1][0:N-1];
    logic [DATA_W-1:0] mem_imag [0:1][0:N-1];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    assign frame_done = en && (wr_cnt == LAST);
    assign last_rd    = (state == READ) && (rd_cnt == LAST);
    assign rd_real    = mem_real[rd_bank][rd_cnt];
    assign rd_imag    = mem_imag[rd_bank][rd_cnt];

`ifdef FFT_OUT_SCALE_EN
    // Divide by N: inf/NaN pass through, tiny values flush to signed zero.
    function automatic logic [DATA_W-1:0] scale_word(input logic [DATA_W-1:0] w);
        logic [7:0] e;
        e = w[30:23];
        if (e == 8'hFF) begin
            scale_word = w;
        end else if (e <= 8'(LOG2N)) begin
            scale_word = {w[DATA_W-1], {(DATA_W-1){1'b0}}};
        end else begin
            scale_word = {w[DATA_W-1], e - 8'(LOG2N), w[22:0]};
        end
    endfunction

    assign nxt_real = scale_word(rd_real);
    assign nxt_imag = scale_word(rd_imag);
`else
    assign nxt_real = rd_real;
    assign nxt_imag = rd_imag;
`endif

    // Write counter advances per accepted sample; bank flips when a frame completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Store each incoming sample at its bit-reversed (natural-order) slot.
    always_ff @(posedge clk) begin
        if (rst && en) begin
            mem_real[wr_bank][bitrev(wr_cnt)] <= in_real;
            mem_imag[wr_bank][bitrev(wr_cnt)] <= in_imag;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: start reading on a completed frame, chain frames back to back.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (frame_done) begin
                    next_state = READ;
                end
            end
            READ: begin
                if ((rd_cnt == LAST) && !frame_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Read pointer: rewinds and latches the freshly completed bank on frame_done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (frame_done) begin
            rd_cnt  <= '0;
            rd_bank <= wr_bank;
        end else if (state == READ) begin
            rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // Output registers: data and index only change while reading.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            finish    <= 1'b0;
        end else begin
            out_valid <= (state == READ);
            finish    <= last_rd;
            if (state == READ) begin
                out_real  <= nxt_real;
                out_imag  <= nxt_imag;
                out_index <= rd_cnt;
            end
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: self-checking bench for fft_output_reorder.
// A frame-level reference model collects accepted samples, and on every
// sixteenth sample queues the frame in natural order. Each clock the DUT
// output is compared with the head of that queue.
// Define FFT_OUT_SCALE_EN for both bench and RTL to check the scaled build.
module tb_fft_output_reorder;

    localparam int DATA_W = 32;
    localparam int N      = 16;
    localparam int LOG2N  = 4;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        int          idx;
        logic        fin;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic [DATA_W-1:0] in_real = '0;
    logic [DATA_W-1:0] in_imag = '0;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic              out_valid;
    logic [LOG2N-1:0]  out_index;
    logic              finish;

    int          total = 0;
    int          bad = 0;
    exp_t        exp_q[$];
    logic [31:0] frame_re [N];
    logic [31:0] frame_im [N];
    int          fill = 0;
    logic [31:0] last_re = '0;
    logic [31:0] last_im = '0;

    fft_output_reorder #(.DATA_W(DATA_W), .N(N), .LOG2N(LOG2N)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .in_real(in_real),
        .in_imag(in_imag),
        .out_real(out_real),
        .out_imag(out_imag),
        .out_valid(out_valid),
        .out_index(out_index),
        .finish(finish)
    );

    always #5 clk = ~clk;

    function automatic int revIndex(input int n);
        int r = 0;
        int v = n;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic logic [31:0] refScale(input logic [31:0] w);
`ifdef FFT_OUT_SCALE_EN
        int e = int'((w >> 23) & 32'hFF);
        if (e == 255) return w;
        if (e <= LOG2N) return w & 32'h8000_0000;
        return w - (32'(LOG2N) << 23);
`else
        return w;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
            $error("[TB] check %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one clock of inputs, then compare the DUT with the model and update the model.
    task automatic applyStimulus(input logic r, input logic e, input logic [31:0] re, input logic [31:0] im);
        exp_t x;
        rst = r;
        en = e;
        in_real = re;
        in_imag = im;
        @(posedge clk);
        #1;
        if (!r) begin
            exp_q.delete();
            fill = 0;
            last_re = '0;
            last_im = '0;
            checkOutput("rst_valid", out_valid, 0);
            checkOutput("rst_finish", finish, 0);
            checkOutput("rst_index", out_index, 0);
            checkOutput("rst_real", out_real, 0);
            checkOutput("rst_imag", out_imag, 0);
        end else begin
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput("valid", out_valid, 1);
                checkOutput("finish", finish, x.fin);
                checkOutput("index", out_index, x.idx);
                checkOutput("real", out_real, x.re);
                checkOutput("imag", out_imag, x.im);
                last_re = x.re;
                last_im = x.im;
            end else begin
                checkOutput("idle_valid", out_valid, 0);
                checkOutput("idle_finish", finish, 0);
                checkOutput("hold_real", out_real, last_re);
                checkOutput("hold_imag", out_imag, last_im);
            end
            if (e) begin
                frame_re[fill] = re;
                frame_im[fill] = im;
                fill++;
                if (fill == N) begin
                    for (int n = 0; n < N; n++) begin
                        x.re  = refScale(frame_re[revIndex(n)]);
                        x.im  = refScale(frame_im[revIndex(n)]);
                        x.idx = n;
                        x.fin = (n == N - 1);
                        exp_q.push_back(x);
                    end
                    fill = 0;
                end
            end
        end
    endtask

    task automatic idleCycles(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b1, 1'b0, $urandom, $urandom);
        end
    endtask

    initial begin
        logic [31:0] scale_vec [4];
        scale_vec[0] = 32'h4180_0000;
        scale_vec[1] = 32'hC180_0000;
        scale_vec[2] = 32'h0200_0000;
        scale_vec[3] = 32'h7FC0_0000;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0);

        $display("[TB] single frame with known data");
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b1, 1'b1, 32'h100 + k, 32'h200 + k);
        end
        idleCycles(N + 2);

        $display("[TB] three back-to-back random frames");
        for (int k = 0; k < 3 * N; k++) begin
            applyStimulus(1'b1, 1'b1, $urandom, $urandom);
        end
        idleCycles(N + 2);

        $display("[TB] en toggling every cycle");
        for (int k = 0; k < 2 * N; k++) begin
            if (k % 2 == 0) begin
                applyStimulus(1'b1, 1'b1, 32'h100 + k / 2, 32'h200 + k / 2);
            end else begin
                applyStimulus(1'b1, 1'b0, $urandom, $urandom);
            end
        end
        idleCycles(N + 2);

        $display("[TB] reset after partial frame");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 1'b1, $urandom, $urandom);
        end
        applyStimulus(1'b0, 1'b0, $urandom, $urandom);
        applyStimulus(1'b0, 1'b1, $urandom, $urandom);
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b1, 1'b1, $urandom, $urandom);
        end
        idleCycles(N + 2);

        $display("[TB] reset during readout at index 5");
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b1, 1'b1, $urandom | 32'h1, $urandom | 32'h1);
        end
        idleCycles(6);
        applyStimulus(1'b0, 1'b0, $urandom, $urandom);
        idleCycles(N + 4);

        $display("[TB] exponent boundary words");
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b1, 1'b1, scale_vec[k % 4], scale_vec[(k + 1) % 4]);
        end
        idleCycles(N + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
